mem_access_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 20 ++
 rtl/mem_wait_counter.sv | 51 +++++
 rtl/mem_access_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS MEM stage: the MEM-stage FSM state encoding,
// datapath widths, and the read-data value returned when a memory access
// times out.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Read data returned to write-back when an access is forced to complete.
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

endpackage : mips_pkg

// File: rtl/mem_wait_counter.sv
// -----------------------------------------------------------------------------
// mem_wait_counter
// Counts cycles a data-memory request has been waiting for its ack.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   clr_i  in  clear the count (takes priority over en_i)
//   en_i   in  count one more waiting cycle
//   hit_o  out count has reached TIMEOUT (the count saturates there)
// -----------------------------------------------------------------------------
module mem_wait_counter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == CNT_MAX);

endmodule : mem_wait_counter

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MIPS MEM stage. Holds the EX/MEM pipeline register, resolves branches,
// performs loads/stores over a variable-latency req/ack data-memory port
// (stalling upstream while an access is outstanding) and drives the MEM/WB
// register.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid + EX outputs            add_result, alu_result, read_data2_out,
//                                    mux_out, zero_out, control bits
//   stall                            hold IF/ID/EX
//   PCSrc, branch_target             branch decision from the EX/MEM entry
//   dmem_req/we/addr/wdata           data-memory request
//   dmem_rdata, dmem_ack             data-memory response
//   wb_*                             MEM/WB register
//   mem_error                        sticky access-timeout flag
// -----------------------------------------------------------------------------
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] add_result,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_data2_out,
  input  logic [REG_W-1:0]  mux_out,
  input  logic              zero_out,
  input  logic              MemtoReg_out,
  input  logic              RegWrite_out,
  input  logic              MemRead_out,
  input  logic              MemWrite_out,
  input  logic              Branch_out,
  output logic              stall,
  output logic              PCSrc,
  output logic [DATA_W-1:0] branch_target,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic              wb_MemtoReg,
  output logic              wb_RegWrite,
  output logic              mem_error
);

  // EX/MEM register
  logic              em_valid_q;
  logic [DATA_W-1:0] em_add_result_q;
  logic [DATA_W-1:0] em_alu_result_q;
  logic [DATA_W-1:0] em_wdata_q;
  logic [REG_W-1:0]  em_mux_out_q;
  logic              em_zero_q;
  logic              em_MemtoReg_q;
  logic              em_RegWrite_q;
  logic              em_MemRead_q;
  logic              em_MemWrite_q;
  logic              em_Branch_q;

  mem_state_e state_q;
  mem_state_e state_d;

  logic              wb_valid_q;
  logic              wb_valid_d;
  logic [DATA_W-1:0] wb_read_data_q;
  logic [DATA_W-1:0] wb_read_data_d;
  logic [DATA_W-1:0] wb_alu_result_q;
  logic [REG_W-1:0]  wb_write_reg_q;
  logic              wb_MemtoReg_q;
  logic              wb_RegWrite_q;
  logic              mem_error_q;
  logic              mem_error_d;

  logic busy_s;
  logic hit_s;
  logic stall_s;
  logic em_mem_op_s;
  logic em_load_s;
  logic in_mem_op_s;
  logic capture_s;
  logic complete_s;
  logic timeout_s;

  assign busy_s      = (state_q == BUSY);
  assign em_mem_op_s = em_valid_q & (em_MemRead_q | em_MemWrite_q);
  // Read+write together is a store, so only a pure read is a load.
  assign em_load_s   = em_MemRead_q & ~em_MemWrite_q;
  assign in_mem_op_s = in_valid & (MemRead_out | MemWrite_out);

  // Stall only while waiting: an ack or the timeout cycle releases upstream
  // in the same cycle, so a single-cycle access costs no bubble.
  assign stall_s    = busy_s & ~dmem_ack & ~hit_s;
  assign capture_s  = ~stall_s;
  assign timeout_s  = busy_s & hit_s & ~dmem_ack;
  // A memory op in EX/MEM always coexists with BUSY, so busy_s & ~stall_s is
  // its completion; any other valid entry completes immediately.
  assign complete_s = em_valid_q & (em_mem_op_s ? (busy_s & ~stall_s) : 1'b1);

  mem_wait_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (capture_s & in_mem_op_s),
    .en_i  (busy_s & ~dmem_ack),
    .hit_o (hit_s)
  );

  // EX/MEM register: load on every non-stalled edge, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_valid_q      <= 1'b0;
      em_add_result_q <= '0;
      em_alu_result_q <= '0;
      em_wdata_q      <= '0;
      em_mux_out_q    <= '0;
      em_zero_q       <= 1'b0;
      em_MemtoReg_q   <= 1'b0;
      em_RegWrite_q   <= 1'b0;
      em_MemRead_q    <= 1'b0;
      em_MemWrite_q   <= 1'b0;
      em_Branch_q     <= 1'b0;
    end else if (capture_s) begin
      em_valid_q      <= in_valid;
      em_add_result_q <= add_result;
      em_alu_result_q <= alu_result;
      em_wdata_q      <= read_data2_out;
      em_mux_out_q    <= mux_out;
      em_zero_q       <= zero_out;
      em_MemtoReg_q   <= MemtoReg_out;
      em_RegWrite_q   <= RegWrite_out;
      em_MemRead_q    <= MemRead_out;
      em_MemWrite_q   <= MemWrite_out;
      em_Branch_q     <= Branch_out;
    end
  end

  // FSM next state: BUSY whenever a memory op is (or stays) in EX/MEM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_mem_op_s) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (stall_s) begin
          state_d = BUSY;
        end else if (in_mem_op_s) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // MEM/WB next values and the sticky timeout flag.
  always_comb begin
    wb_valid_d     = complete_s;
    wb_read_data_d = TIMEOUT_RDATA;
    mem_error_d    = mem_error_q | timeout_s;
    if (em_mem_op_s && em_load_s && dmem_ack) begin
      wb_read_data_d = dmem_rdata;
    end else begin
      wb_read_data_d = TIMEOUT_RDATA;
    end
  end

  // MEM/WB register: data fields update only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q      <= 1'b0;
      wb_read_data_q  <= '0;
      wb_alu_result_q <= '0;
      wb_write_reg_q  <= '0;
      wb_MemtoReg_q   <= 1'b0;
      wb_RegWrite_q   <= 1'b0;
      mem_error_q     <= 1'b0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      mem_error_q <= mem_error_d;
      if (complete_s) begin
        wb_read_data_q  <= wb_read_data_d;
        wb_alu_result_q <= em_alu_result_q;
        wb_write_reg_q  <= em_mux_out_q;
        wb_MemtoReg_q   <= em_MemtoReg_q;
        wb_RegWrite_q   <= em_RegWrite_q;
      end
    end
  end

  assign stall         = stall_s;
  assign PCSrc         = em_valid_q & em_Branch_q & em_zero_q;
  assign branch_target = em_add_result_q;
  assign dmem_req      = busy_s;
  assign dmem_we       = busy_s & em_MemWrite_q;
  assign dmem_addr     = em_alu_result_q;
  assign dmem_wdata    = em_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_write_reg  = wb_write_reg_q;
  assign wb_MemtoReg   = wb_MemtoReg_q;
  assign wb_RegWrite   = wb_RegWrite_q;
  assign mem_error     = mem_error_q;

endmodule : mem_access_stage

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Directed scenario tasks followed by a randomized run checked against an
// instruction-level model of the MEM stage.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] add_result, alu_result, read_data2_out;
  logic [4:0]  mux_out;
  logic        zero_out, MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out;
  logic        stall, PCSrc;
  logic [31:0] branch_target;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [31:0] wb_read_data, wb_alu_result;
  logic [4:0]  wb_write_reg;
  logic        wb_MemtoReg, wb_RegWrite, mem_error;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage #(.TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .add_result(add_result), .alu_result(alu_result), .read_data2_out(read_data2_out),
    .mux_out(mux_out), .zero_out(zero_out),
    .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .Branch_out(Branch_out),
    .stall(stall), .PCSrc(PCSrc), .branch_target(branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
    .wb_write_reg(wb_write_reg), .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite),
    .mem_error(mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic rd, input logic wr, input logic br,
                        input logic z, input logic [31:0] add, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] mux, input logic m2r,
                        input logic rw);
    in_valid = v; MemRead_out = rd; MemWrite_out = wr; Branch_out = br; zero_out = z;
    add_result = add; alu_result = alu; read_data2_out = wd; mux_out = mux;
    MemtoReg_out = m2r; RegWrite_out = rw;
  endtask

  task automatic test_reset();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    rst_n = 1'b0;
    #22;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", dmem_req); end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wbv got %b exp 0", wb_valid); end
    n_checks++; if (mem_error !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", mem_error); end
    n_checks++; if (PCSrc !== 1'b0) begin n_fail++; $display("FAIL reset_pcsrc got %b exp 0", PCSrc); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_branch();
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h5, 32'h0, 5'd2, 1'b0, 1'b0);
    cyc();
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h6, 32'h0, 5'd3, 1'b0, 1'b0);
    #1;
    n_checks++; if (PCSrc !== 1'b1) begin n_fail++; $display("FAIL br_taken got %b exp 1", PCSrc); end
    n_checks++; if (branch_target !== 32'h40) begin n_fail++; $display("FAIL br_target got %h exp 00000040", branch_target); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL br_stall got %b exp 0", stall); end
    cyc();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    n_checks++; if (PCSrc !== 1'b0) begin n_fail++; $display("FAIL br_notzero got %b exp 0", PCSrc); end
    cyc();
    n_checks++; if (PCSrc !== 1'b0) begin n_fail++; $display("FAIL br_idle got %b exp 0", PCSrc); end
  endtask

  task automatic test_load_latency();
    int stalls = 0;
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h100, 32'h0, 5'd8, 1'b1, 1'b1);
    cyc();
    // Garbage on the EX side that must be ignored while stalled.
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hDEAD, 32'hBEEF, 5'd31, 1'b0, 1'b0);
    dmem_ack = 1'b0;
    #1;
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL ld_req got %b exp 1", dmem_req); end
    n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL ld_we got %b exp 0", dmem_we); end
    n_checks++; if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL ld_addr got %h exp 00000100", dmem_addr); end
    if (stall === 1'b1) stalls++;
    cyc();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL ld_bubble got %b exp 0", wb_valid); end
    n_checks++; if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL ld_addr_hold got %h exp 00000100", dmem_addr); end
    if (stall === 1'b1) stalls++;
    cyc();
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_BABE;
    #1;
    if (stall === 1'b1) stalls++;
    n_checks++; if (stalls !== 2) begin n_fail++; $display("FAIL ld_stall_cycles got %0d exp 2", stalls); end
    cyc();
    dmem_ack = 1'b0;
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL ld_wbv got %b exp 1", wb_valid); end
    n_checks++; if (wb_read_data !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL ld_rdata got %h exp cafebabe", wb_read_data); end
    n_checks++; if (wb_write_reg !== 5'd8) begin n_fail++; $display("FAIL ld_reg got %0d exp 8", wb_write_reg); end
    n_checks++; if (wb_alu_result !== 32'h100) begin n_fail++; $display("FAIL ld_alu got %h exp 00000100", wb_alu_result); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL ld_idle_req got %b exp 0", dmem_req); end
    cyc();
  endtask

  task automatic test_store_fast();
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h20, 32'h1234, 5'd0, 1'b0, 1'b0);
    cyc();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
    #1;
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL st_req got %b exp 1", dmem_req); end
    n_checks++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL st_we got %b exp 1", dmem_we); end
    n_checks++; if (dmem_wdata !== 32'h1234) begin n_fail++; $display("FAIL st_wdata got %h exp 00001234", dmem_wdata); end
    n_checks++; if (dmem_addr !== 32'h20) begin n_fail++; $display("FAIL st_addr got %h exp 00000020", dmem_addr); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL st_stall got %b exp 0", stall); end
    cyc();
    dmem_ack = 1'b0;
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL st_wbv got %b exp 1", wb_valid); end
    n_checks++; if (wb_read_data !== 32'h0) begin n_fail++; $display("FAIL st_rdata got %h exp 00000000", wb_read_data); end
    cyc();
  endtask

  task automatic test_back_to_back();
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 5'd3, 1'b1, 1'b1);
    cyc();
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h300, 32'h0, 5'd4, 1'b1, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got %b exp 0", stall); end
    cyc();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    dmem_ack = 1'b1; dmem_rdata = 32'h2222_2222;
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_wbv1 got %b exp 1", wb_valid); end
    n_checks++; if (wb_read_data !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_rd1 got %h exp 11111111", wb_read_data); end
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req2 got %b exp 1", dmem_req); end
    n_checks++; if (dmem_addr !== 32'h300) begin n_fail++; $display("FAIL b2b_addr2 got %h exp 00000300", dmem_addr); end
    cyc();
    dmem_ack = 1'b0;
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_wbv2 got %b exp 1", wb_valid); end
    n_checks++; if (wb_read_data !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_rd2 got %h exp 22222222", wb_read_data); end
    n_checks++; if (wb_write_reg !== 5'd4) begin n_fail++; $display("FAIL b2b_reg2 got %0d exp 4", wb_write_reg); end
    cyc();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_after got %b exp 0", wb_valid); end
  endtask

  task automatic test_timeout();
    int stalls = 0;
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h400, 32'h0, 5'd9, 1'b1, 1'b1);
    cyc();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    dmem_ack = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
    #1;
    while (stall === 1'b1 && stalls < 40) begin
      stalls++;
      cyc();
      #1;
    end
    n_checks++; if (stalls !== TMO) begin n_fail++; $display("FAIL to_stall_cycles got %0d exp %0d", stalls, TMO); end
    n_checks++; if (mem_error !== 1'b0) begin n_fail++; $display("FAIL to_err_early got %b exp 0", mem_error); end
    cyc();
    n_checks++; if (mem_error !== 1'b1) begin n_fail++; $display("FAIL to_err got %b exp 1", mem_error); end
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL to_wbv got %b exp 1", wb_valid); end
    n_checks++; if (wb_read_data !== 32'h0) begin n_fail++; $display("FAIL to_rdata got %h exp 00000000", wb_read_data); end
    cyc();
    n_checks++; if (mem_error !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky got %b exp 1", mem_error); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL to_idle_req got %b exp 0", dmem_req); end
  endtask

  task automatic test_reset_mid_access();
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h500, 32'h0, 5'd7, 1'b1, 1'b1);
    cyc();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    cyc();
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got %b exp 1", dmem_req); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req got %b exp 0", dmem_req); end
    n_checks++; if ({wb_valid, wb_read_data, wb_alu_result, wb_write_reg, wb_MemtoReg, wb_RegWrite} !== 72'h0)
      begin n_fail++; $display("FAIL rst_mid_wb got %h exp 0", {wb_valid, wb_read_data, wb_alu_result, wb_write_reg, wb_MemtoReg, wb_RegWrite}); end
    n_checks++; if (mem_error !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err got %b exp 0", mem_error); end
    #3;
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
    cyc();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack got %b exp 0", wb_valid); end
    cyc();
    dmem_ack = 1'b0;
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack2 got %b exp 0", wb_valid); end
  endtask

  // Randomized run against an instruction-level model: the model tracks the
  // instruction occupying MEM and how long it has waited for memory.
  task automatic test_random();
    logic        c_v = 1'b0, c_rd = 1'b0, c_wr = 1'b0, c_br = 1'b0, c_z = 1'b0, c_m2r = 1'b0, c_rw = 1'b0;
    logic [31:0] c_add = 32'h0, c_alu = 32'h0, c_wd = 32'h0;
    logic [4:0]  c_mux = 5'd0;
    bit          c_noack = 1'b0;
    int          waited = 0;
    logic        e_wbv = 1'b0, e_m2r = 1'b0, e_rw = 1'b0, e_err = 1'b0;
    logic [31:0] e_rdata = 32'h0, e_alu = 32'h0;
    logic [4:0]  e_reg = 5'd0;
    for (int it = 0; it < 600; it++) begin
      bit is_mem, ack, exp_stall, done;
      is_mem = c_v && (c_rd || c_wr);
      set_ex($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, 1), $urandom_range(0, 1));
      ack = is_mem ? (!c_noack && $urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 1);
      dmem_ack = ack;
      dmem_rdata = $urandom;
      #1;
      exp_stall = is_mem && !ack && waited < TMO;
      n_checks++; if (stall !== exp_stall) begin n_fail++; $display("FAIL rnd_stall it=%0d got %b exp %b", it, stall, exp_stall); end
      n_checks++; if (dmem_req !== is_mem) begin n_fail++; $display("FAIL rnd_req it=%0d got %b exp %b", it, dmem_req, is_mem); end
      if (is_mem) begin
        n_checks++;
        if ({dmem_we, dmem_addr, dmem_wdata} !== {c_wr, c_alu, c_wd})
          begin n_fail++; $display("FAIL rnd_dmem it=%0d got %b/%h/%h exp %b/%h/%h", it, dmem_we, dmem_addr, dmem_wdata, c_wr, c_alu, c_wd); end
      end
      n_checks++; if (PCSrc !== (c_v && c_br && c_z)) begin n_fail++; $display("FAIL rnd_pcsrc it=%0d got %b exp %b", it, PCSrc, c_v && c_br && c_z); end
      done = c_v && (!is_mem || ack || waited >= TMO);
      e_wbv = done;
      if (done) begin
        e_rdata = (is_mem && c_rd && !c_wr && ack) ? dmem_rdata : 32'h0;
        e_alu = c_alu; e_reg = c_mux; e_m2r = c_m2r; e_rw = c_rw;
      end
      if (is_mem && !ack && waited >= TMO) e_err = 1'b1;
      if (!exp_stall) begin
        c_v = in_valid; c_rd = MemRead_out; c_wr = MemWrite_out; c_br = Branch_out; c_z = zero_out;
        c_add = add_result; c_alu = alu_result; c_wd = read_data2_out; c_mux = mux_out;
        c_m2r = MemtoReg_out; c_rw = RegWrite_out;
        c_noack = ($urandom_range(0, 7) == 0);
        waited = 0;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({wb_valid, wb_read_data, wb_alu_result, wb_write_reg, wb_MemtoReg, wb_RegWrite} !==
          {e_wbv, e_rdata, e_alu, e_reg, e_m2r, e_rw})
        begin n_fail++; $display("FAIL rnd_wb it=%0d got %b/%h/%h/%0d/%b/%b exp %b/%h/%h/%0d/%b/%b", it,
          wb_valid, wb_read_data, wb_alu_result, wb_write_reg, wb_MemtoReg, wb_RegWrite,
          e_wbv, e_rdata, e_alu, e_reg, e_m2r, e_rw); end
      n_checks++; if (mem_error !== e_err) begin n_fail++; $display("FAIL rnd_err it=%0d got %b exp %b", it, mem_error, e_err); end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    test_reset();
    test_branch();
    test_load_latency();
    test_store_fast();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_access_stage
